// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared constants and state encoding for the data memory
package dmem_pkg;

    localparam int ADDR_W_DEF      = 6;
    localparam int DATA_W_DEF      = 32;
    localparam int LATENCY_DEF     = 5;
    localparam int BYTES_PER_BLOCK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/data_memory_if.sv
// rtl/data_memory_if.sv - cache-to-memory block bus with busywait handshake
interface data_memory_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );

endinterface

// File: rtl/data_memory_array.sv
// rtl/data_memory_array.sv - synchronous word storage with one write port and a registered read port
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately left out of reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - main data memory with fixed multi-cycle latency behind a busywait handshake
module data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic          clk,
    input  logic          reset,
    data_memory_if.slave  bus
);

    localparam int LAT_EFF = (LATENCY < 1) ? 1 : LATENCY;
    localparam int CNT_W   = (LAT_EFF > 1) ? $clog2(LAT_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;

    logic req_valid;
    logic access;

    assign req_valid = bus.read ^ bus.write;
    // Gating with reset aborts an access that would otherwise land on the reset edge.
    assign access    = (state_q == BUSY) && (cnt_q == '0) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= bus.address;
                        wdata_q <= bus.writedata;
                        we_q    <= bus.write;
                        cnt_q   <= CNT_LOAD;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busywait = ((state_q == IDLE) && req_valid) || (state_q == BUSY);

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .en_i    (access),
        .we_i    (we_q),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (bus.readdata)
    );

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory
module tb_data_memory;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_memory_if #(.ADDR_W(6), .DATA_W(32)) bus  ();
    data_memory_if #(.ADDR_W(6), .DATA_W(32)) bus1 ();

    data_memory #(.ADDR_W(6), .DATA_W(32), .LATENCY(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    data_memory #(.ADDR_W(6), .DATA_W(32), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [64];
    logic [31:0] ref_rd;
    vec_t        tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [5:0] a, input logic [31:0] d);
        if (sel == 1) begin
            bus1.read = rd; bus1.write = wr; bus1.address = a; bus1.writedata = d;
        end else begin
            bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = d;
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 1) ? bus1.busywait : bus.busywait;
    endfunction

    function automatic logic [31:0] get_rd(input int sel);
        return (sel == 1) ? bus1.readdata : bus.readdata;
    endfunction

    // Issues one request from IDLE and returns #1 after the completion edge (in DONE).
    task automatic access(input int sel, input logic wr, input logic [5:0] a,
                          input logic [31:0] d, input int exp_lat, input string name);
        int edges;
        edges = 0;
        @(posedge clk); #1;
        drive(sel, !wr, wr, a, d);
        #1;
        check($sformatf("%s busy_at_request", name), 32'(get_busy(sel)), 32'd1);
        @(posedge clk); #1;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (get_busy(sel) && edges < 20);
        drive(sel, 1'b0, 1'b0, a, d);
        check($sformatf("%s latency", name), 32'(edges), 32'(exp_lat));
    endtask

    initial begin
        int edges;
        logic        wr;
        logic [5:0]  a;
        logic [31:0] d;

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 6'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 6'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busywait", 32'(bus.busywait), 32'd0);
        check("reset readdata", bus.readdata, 32'h0);
        check("reset busywait lat1", 32'(bus1.busywait), 32'd0);
        check("reset readdata lat1", bus1.readdata, 32'h0);
        ref_rd = 32'h0;

        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom;
            access(0, 1'b1, 6'(i), ref_mem[i], 5, "preload");
        end
        check("readdata after writes only", bus.readdata, ref_rd);

        tbl[0] = '{1'b1, 6'h05, 32'hDEADBEEF, 32'h00000000};
        tbl[1] = '{1'b0, 6'h05, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 6'h01, 32'hA5A5A5A5, 32'hDEADBEEF};
        tbl[3] = '{1'b1, 6'h02, 32'h5A5A5A5A, 32'hDEADBEEF};
        tbl[4] = '{1'b1, 6'h07, 32'h11223344, 32'hDEADBEEF};
        tbl[5] = '{1'b0, 6'h07, 32'h0,        32'h11223344};
        tbl[6] = '{1'b0, 6'h01, 32'h0,        32'hA5A5A5A5};
        for (int i = 0; i < 7; i++) begin
            access(0, tbl[i].wr, tbl[i].addr, tbl[i].data, 5, $sformatf("vec%0d", i));
            check($sformatf("vec%0d readdata", i), bus.readdata, tbl[i].exp_rd);
            if (tbl[i].wr) ref_mem[tbl[i].addr] = tbl[i].data;
            else           ref_rd = ref_mem[tbl[i].addr];
        end

        // Address change while BUSY must not redirect the access.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 6'h01, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.address = 6'h02;
        edges = 0;
        while (bus.busywait && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        drive(0, 1'b0, 1'b0, 6'h0, 32'h0);
        check("midbusy readdata", bus.readdata, 32'hA5A5A5A5);
        ref_rd = 32'hA5A5A5A5;

        // Read held through DONE: guard cycle, then a fresh acceptance from IDLE.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 6'h05, 32'h0);
        @(posedge clk); #1;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (bus.busywait && edges < 20);
        check("b2b first latency", 32'(edges), 32'd5);
        check("b2b busy in DONE", 32'(bus.busywait), 32'd0);
        check("b2b first readdata", bus.readdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("b2b busy back in IDLE", 32'(bus.busywait), 32'd1);
        @(posedge clk); #1;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (bus.busywait && edges < 20);
        drive(0, 1'b0, 1'b0, 6'h0, 32'h0);
        check("b2b second latency", 32'(edges), 32'd5);
        check("b2b second readdata", bus.readdata, 32'hDEADBEEF);
        ref_rd = 32'hDEADBEEF;

        // read && write together is not a request.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 6'h07, 32'h1);
        #1;
        check("illegal busy comb", 32'(bus.busywait), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("illegal busy edge%0d", i), 32'(bus.busywait), 32'd0);
        end
        drive(0, 1'b0, 1'b0, 6'h0, 32'h0);
        access(0, 1'b0, 6'h07, 32'h0, 5, "illegal readback");
        check("illegal readback data", bus.readdata, 32'h11223344);
        ref_rd = 32'h11223344;

        // Reset during BUSY aborts the write and clears readdata.
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 6'h0A, 32'h12345678);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 6'h0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busywait", 32'(bus.busywait), 32'd0);
        check("abort readdata", bus.readdata, 32'h0);
        access(0, 1'b0, 6'h0A, 32'h0, 5, "abort readback");
        check("abort readback data", bus.readdata, ref_mem[6'h0A]);
        ref_rd = ref_mem[6'h0A];

        for (int i = 0; i < 150; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 6'($urandom_range(0, 63));
            d  = $urandom;
            access(0, wr, a, d, 5, $sformatf("rand%0d", i));
            if (wr) ref_mem[a] = d;
            else    ref_rd = ref_mem[a];
            check($sformatf("rand%0d readdata", i), bus.readdata, ref_rd);
        end

        access(1, 1'b1, 6'h03, 32'hCAFEF00D, 1, "lat1 write");
        check("lat1 readdata after write", bus1.readdata, 32'h0);
        access(1, 1'b0, 6'h03, 32'h0, 1, "lat1 read");
        check("lat1 readdata", bus1.readdata, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
